// File: rtl/button_conditioner_pkg.sv
// Shared types and timing defaults for the push-button conditioner.
// Select FSM states, default-timing divisors and the counter-width helper.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        SEL_IDLE = 2'd0,
        SEL_HELD = 2'd1,
        SEL_LONG = 2'd2
    } sel_state_t;

    localparam int DEF_CLK_HZ  = 50_000_000;
    localparam int DEB_DIV     = 50;
    localparam int RPT_DLY_DIV = 2;
    localparam int RPT_PER_NUM = 3;
    localparam int RPT_PER_DEN = 20;

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one active-low pin.
// A press is only reported once the pin has been seen released after reset.
module btn_debounce
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin_n,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_vld;
    logic          r_armed;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          w_in;
    logic          w_flip;

    assign w_in   = ~r_sync2;
    assign w_flip = (w_in != r_level) && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_vld     <= 2'b00;
            r_armed   <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_pin_n;
            r_sync2   <= r_sync1;
            r_vld     <= {r_vld[0], 1'b1};
            // Arm only after the real pin has reached the sync output.
            if (r_vld[1] && !w_in)
                r_armed <= 1'b1;
            r_press   <= w_flip && w_in && r_armed;
            r_release <= w_flip && !w_in;
            if (w_in == r_level) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_level <= w_in;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// Debounces up/down/select pins into single-cycle events; select is short/long.
// Optional auto-repeat on up/down is enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int CLK_HZ          = DEF_CLK_HZ,
    parameter int DEBOUNCE_CYCLES = CLK_HZ / DEB_DIV,
    parameter int LONG_CYCLES     = CLK_HZ,
    parameter int REPEAT_DELAY    = CLK_HZ / RPT_DLY_DIV,
    parameter int REPEAT_PERIOD   = CLK_HZ / RPT_PER_DEN * RPT_PER_NUM
) (
    input  logic clk,
    input  logic rst,
    input  logic up_n,
    input  logic down_n,
    input  logic select_n,
    output logic up,
    output logic down,
    output logic select,
    output logic select_long
);

    localparam int HW = cnt_w(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic [1:0]    w_lvl;
    logic [1:0]    w_prs;
    logic [1:0]    w_ev;
    logic [2:0]    w_rel;
    logic          w_sel_lvl;
    logic          w_sel_prs;
    sel_state_t    r_state;
    sel_state_t    w_state_nx;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nx;
    logic          w_sel_nx;
    logic          w_long_nx;
    logic          r_up;
    logic          r_down;
    logic          r_select;
    logic          r_long;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .rst(rst), .i_pin_n(up_n),
        .o_level(w_lvl[0]), .o_press(w_prs[0]), .o_release(w_rel[0])
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .rst(rst), .i_pin_n(down_n),
        .o_level(w_lvl[1]), .o_press(w_prs[1]), .o_release(w_rel[1])
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
        .clk(clk), .rst(rst), .i_pin_n(select_n),
        .o_level(w_sel_lvl), .o_press(w_sel_prs), .o_release(w_rel[2])
    );

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = cnt_w(RMAX);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [1:0] w_rpt;
    logic       w_unused;

    assign w_unused = ^w_rel;

    for (genvar g = 0; g < 2; g++) begin : g_rpt
        logic [RW-1:0] r_cnt;
        logic          r_act;
        logic          r_per;

        // r_act gates repeats to presses that actually produced a pulse.
        assign w_rpt[g] = r_act && w_lvl[g] &&
                          (r_cnt == (r_per ? PER_LAST : DLY_LAST));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
                r_act <= 1'b0;
                r_per <= 1'b0;
            end else if (!w_lvl[g]) begin
                r_cnt <= '0;
                r_act <= 1'b0;
                r_per <= 1'b0;
            end else if (w_prs[g]) begin
                r_cnt <= '0;
                r_act <= 1'b1;
                r_per <= 1'b0;
            end else if (w_rpt[g]) begin
                r_cnt <= '0;
                r_per <= 1'b1;
            end else if (r_act) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_ev = w_prs | w_rpt;
`else
    logic w_unused;

    assign w_unused = ^{w_rel, w_lvl};
    assign w_ev     = w_prs;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_hold_nx  = r_hold;
        w_sel_nx   = 1'b0;
        w_long_nx  = 1'b0;
        unique case (r_state)
            SEL_IDLE: begin
                if (w_sel_prs) begin
                    w_state_nx = SEL_HELD;
                    w_hold_nx  = '0;
                end
            end
            SEL_HELD: begin
                if (!w_sel_lvl) begin
                    w_state_nx = SEL_IDLE;
                    w_sel_nx   = 1'b1;
                end else if (r_hold == HOLD_LAST) begin
                    w_state_nx = SEL_LONG;
                    w_long_nx  = 1'b1;
                end else begin
                    w_hold_nx = r_hold + 1'b1;
                end
            end
            SEL_LONG: begin
                if (!w_sel_lvl)
                    w_state_nx = SEL_IDLE;
            end
            default: w_state_nx = SEL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= SEL_IDLE;
            r_hold   <= '0;
            r_up     <= 1'b0;
            r_down   <= 1'b0;
            r_select <= 1'b0;
            r_long   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_hold   <= w_hold_nx;
            // Coincident up/down events cancel each other.
            r_up     <= w_ev[0] & ~w_ev[1];
            r_down   <= w_ev[1] & ~w_ev[0];
            r_select <= w_sel_nx;
            r_long   <= w_long_nx;
        end
    end

    assign up          = r_up;
    assign down        = r_down;
    assign select      = r_select;
    assign select_long = r_long;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with shortened timing parameters.
// Pulse counts and first/last pulse cycles are tracked per output.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic up_n;
    logic down_n;
    logic select_n;
    logic up;
    logic down;
    logic select;
    logic select_long;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mark  = 0;
    int n_p [4];
    int f_p [4];
    int l_p [4];

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(8),
        .LONG_CYCLES(64),
        .REPEAT_DELAY(32),
        .REPEAT_PERIOD(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .up_n(up_n),
        .down_n(down_n),
        .select_n(select_n),
        .up(up),
        .down(down),
        .select(select),
        .select_long(select_long)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 4; i++) begin
            n_p[i] = 0;
            f_p[i] = -1;
            l_p[i] = -1;
        end
    endtask

    // Index 0 up, 1 down, 2 select, 3 select_long.
    task automatic run(input int n);
        logic [3:0] o;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            o = {select_long, select, down, up};
            for (int i = 0; i < 4; i++) begin
                if (o[i]) begin
                    if (n_p[i] == 0)
                        f_p[i] = cyc;
                    l_p[i] = cyc;
                    n_p[i]++;
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        up_n     = 1'b1;
        down_n   = 1'b1;
        select_n = 1'b1;
        clr();
        run(3);
        check("rst_outputs", int'({up, down, select, select_long}), 0);
        check("rst_level", int'(dut.u_up.o_level), 0);
        rst = 1'b0;
        run(5);

        // Short glitch must not be accepted.
        clr();
        up_n = 1'b0;
        run(5);
        up_n = 1'b1;
        run(20);
        check("glitch_up_cnt", n_p[0], 0);
        check("glitch_level", int'(dut.u_up.o_level), 0);

        // Bouncing press: 2 sync + 8 debounce to level, pulse one cycle later.
        clr();
        up_n = 1'b0;
        run(2);
        up_n = 1'b1;
        run(2);
        up_n = 1'b0;
        run(2);
        up_n = 1'b1;
        run(2);
        up_n = 1'b0;
        mark = cyc;
        run(20);
        check("bounce_up_cnt", n_p[0], 1);
        check("bounce_up_lat", f_p[0] - mark, 11);
        check("bounce_level", int'(dut.u_up.o_level), 1);
        check("bounce_down_cnt", n_p[1], 0);
        clr();
        up_n = 1'b1;
        run(20);
        check("up_release_cnt", n_p[0], 0);
        check("up_release_level", int'(dut.u_up.o_level), 0);

        // Short select: pulse when the FSM sees the debounced release.
        clr();
        select_n = 1'b0;
        run(30);
        select_n = 1'b1;
        mark = cyc;
        run(20);
        check("short_sel_cnt", n_p[2], 1);
        check("short_sel_lat", f_p[2] - mark, 11);
        check("short_long_cnt", n_p[3], 0);

        // Long select: level at +10, HELD at +11, 64 hold cycles later.
        clr();
        select_n = 1'b0;
        mark = cyc;
        run(200);
        check("long_cnt", n_p[3], 1);
        check("long_lat", f_p[3] - mark, 75);
        check("long_sel_held", n_p[2], 0);
        select_n = 1'b1;
        run(20);
        check("long_sel_rel", n_p[2], 0);

        // Simultaneous up/down press cancels both.
        clr();
        up_n   = 1'b0;
        down_n = 1'b0;
        run(20);
        check("simul_up_cnt", n_p[0], 0);
        check("simul_down_cnt", n_p[1], 0);
        check("simul_levels", int'({dut.u_up.o_level, dut.u_down.o_level}), 3);
        up_n   = 1'b1;
        down_n = 1'b1;
        run(20);
        check("simul_rel_cnt", n_p[0] + n_p[1], 0);

        // Held down: repeats at t0+32 then every 16 when enabled.
        clr();
        down_n = 1'b0;
        mark = cyc;
        run(100);
        down_n = 1'b1;
        run(20);
        check("hold_down_first", f_p[1] - mark, 11);
`ifdef BTN_AUTOREPEAT_EN
        check("hold_down_cnt", n_p[1], 6);
        check("hold_down_span", l_p[1] - f_p[1], 96);
`else
        check("hold_down_cnt", n_p[1], 1);
        check("hold_down_span", l_p[1] - f_p[1], 0);
`endif
        check("hold_up_cnt", n_p[0], 0);

        // Reset mid-hold: press discarded until a fresh press.
        clr();
        select_n = 1'b0;
        run(40);
        rst = 1'b1;
        run(2);
        check("midrst_outputs", int'({up, down, select, select_long}), 0);
        rst = 1'b0;
        run(100);
        check("midrst_sel_held", n_p[2], 0);
        check("midrst_long_held", n_p[3], 0);
        select_n = 1'b1;
        run(20);
        check("midrst_sel_rel", n_p[2], 0);
        check("midrst_long_rel", n_p[3], 0);
        clr();
        select_n = 1'b0;
        run(30);
        select_n = 1'b1;
        run(20);
        check("repress_sel_cnt", n_p[2], 1);
        check("repress_long_cnt", n_p[3], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
